uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart_tx byte transmitter among N_REQ byte sources (SDRAM
//  test status, read-data dump, debug). Round-robin arbitration, one byte per grant.
//  Each byte is handed to uart_tx with its level/edge tx_ready + tx_done handshake.
//  Sits between the SDRAM test/debug logic and uart_tx, in the sys_clk_100M domain.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  ID_W         2   width of grant_id; must be >= clog2(N_REQ)
//  ACK_TIMEOUT  16  max cycles in START waiting for tx_done to fall (>= 4)
//  GUARD_CYC    4   cycles tx_ready is held low after a timeout (>= 3)
// PORTS
//  sys_clk_100M  in   1          system clock, all logic on rising edge
//  rst           in   1          synchronous reset, active high
//  req_valid     in   N_REQ      per-requester byte valid; held until accepted
//  req_data      in   8*N_REQ    byte of requester i in [8*i+7:8*i]; stable while valid
//  req_ready     out  N_REQ      one-hot accept; the byte transfers when valid&ready
//  tx_ready      out  1          to uart_tx.tx_ready; level, uart_tx starts on its rise
//  tx_data       out  8          to uart_tx.tx_data; registered, stable while tx_ready=1
//  tx_done       in   1          from uart_tx.tx_done; 1 = transmitter idle
//  busy          out  1          1 whenever state != IDLE
//  grant_id      out  ID_W       index of the requester that owns the current/last byte
//  err_timeout   out  1          one-cycle pulse: uart_tx did not start within ACK_TIMEOUT
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge): state=IDLE; tx_ready=0, tx_data=0, req_ready=0,
//   busy=0, grant_id=0, err_timeout=0; RR pointer=N_REQ-1, so requester 0 is first.
//   Reset mid-transfer drops the byte. tx_ready falls at once; uart_tx finishes its frame.
//  FSM states: IDLE, START, WAIT_DONE, GUARD.
//  IDLE: if tx_done=1 and any req_valid=1, pick the winner w. w is the first valid index
//   after the RR pointer, modulo N_REQ. req_ready[w]=1 is combinational, in this cycle only.
//   At the edge: tx_data<=req_data[w], grant_id<=w, RR pointer<=w, ->START.
//   tx_done=0 in IDLE blocks all grants.
//  START: tx_ready=1, tx_data held. Wait-counter counts from 0.
//   tx_done=0 -> WAIT_DONE; tx_ready=0 from the next cycle.
//   Else if count reaches ACK_TIMEOUT-1: err_timeout=1 for 1 cycle, byte dropped, ->GUARD.
//  WAIT_DONE: tx_ready=0. When tx_done=1 -> IDLE. No timeout here.
//  GUARD: tx_ready=0 for GUARD_CYC cycles, then ->IDLE. This lets the uart_tx 2-FF
//   edge detector see a low level before the next rise.
//  Latency: accept edge -> tx_ready=1 next cycle. uart_tx drops tx_done 3 edges after
//   the first edge that samples tx_ready=1.
//  Throughput: at most 1 byte per UART frame plus 2 cycles. Back-to-back grants are legal.
//   The next IDLE grant comes only after tx_done returns to 1.
//  Simultaneous valids: strict round-robin; a requester that just won has lowest priority next.
//  A requester dropping valid before acceptance is legal; it is simply not granted.
//  req_valid changes during START/WAIT_DONE/GUARD are ignored (req_ready=0 there).
//  grant_id holds its value until the next grant.
// TESTING
//  1 Reset, only req_valid[2]=1, data=8'hA5 -> req_ready=4'b0100 for 1 cycle;
//    uart_tx line shows start bit, then bits 1,0,1,0,0,1,0,1 (LSB first), then stop bit.
//    grant_id=2.
//  2 All 4 valid continuously, data 8'h10..8'h13 -> bytes sent in order 10,11,12,13,10.
//    No grant while tx_done=0.
//  3 tx_done tied 1 (stub uart_tx) with req_valid[0]=1 -> START lasts 16 cycles;
//    err_timeout pulses once; tx_ready low for 4 cycles; then a new grant.
//  4 rst=1 for 1 cycle during WAIT_DONE -> next edge: all outputs at reset values;
//    tx_ready=0; the following grant goes to requester 0.
//  5 req_valid[1] pulses for 1 cycle while busy=1 -> no req_ready[1];
//    the requester is not granted after IDLE.
//  6 Scoreboard: 200 random bytes over random valids -> each byte appears exactly once
//    on the line; per-requester order is preserved.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one byte per grant from N_REQ sources
// to a single uart_tx, with start timeout and post-timeout guard.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int GUARD_CYC   = 4
) (
  input  logic               sys_clk_100M_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               tx_ready_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_done_i,
  output logic               busy_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               err_timeout_o
);

  localparam int CNT_MAX =
    (ACK_TIMEOUT > GUARD_CYC) ? ACK_TIMEOUT : GUARD_CYC;
  localparam int CNT_W = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GUARD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;

  logic             hi_found, lo_found;
  logic [ID_W-1:0]  hi_win, lo_win, win;
  logic [7:0]       win_data;
  logic             grant;

  // Prefer the first valid above the pointer, else wrap to the lowest.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid_i[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_win   = ID_W'(i);
      end
      if (req_valid_i[i] && !hi_found &&
          (ID_W'(i) > rr_q)) begin
        hi_found = 1'b1;
        hi_win   = ID_W'(i);
      end
    end
  end

  assign win   = hi_found ? hi_win : lo_win;
  assign grant = (state_q == IDLE) && tx_done_i && lo_found;

  always_comb begin
    win_data    = '0;
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        win_data       = req_data_i[8*i +: 8];
        req_ready_o[i] = grant;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          data_d  = win_data;
          gid_d   = win;
          rr_d    = win;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (!tx_done_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT-1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_done_i) state_d = IDLE;
      end
      GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYC-1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_100M_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= ID_W'(N_REQ-1);
      gid_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign tx_ready_o    = (state_q == START);
  assign busy_o        = (state_q != IDLE);
  assign tx_data_o     = data_q;
  assign grant_id_o    = gid_q;
  assign err_timeout_o = err_q;

endmodule
